// File: rtl/handshake_rr_control_merge.sv
// handshake_rr_control_merge
// Round-robin control merge for the elastic dataflow fabric. Up to one
// token per cycle is taken from NUM_INPUTS producers and placed in a
// registered output slot, along with the number of the winning channel.
// The rotating priority pointer advances past a winner only when its
// token is actually accepted, so a channel that keeps its request up is
// served within NUM_INPUTS accepted tokens.
//
// Optional build macro: HANDSHAKE_RR_GRANT_CNT_EN
//   When defined, a saturating 16-bit grant_cnt output counts completed
//   input handshakes. When undefined, the port and counter are absent.
module handshake_rr_control_merge #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic                             outs_valid,
  input  logic                             outs_ready,
  output logic [INDEX_WIDTH-1:0]           index
`ifdef HANDSHAKE_RR_GRANT_CNT_EN
  ,
  output logic [15:0]                      grant_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  // Arbitration results and slot control.
  logic [INDEX_WIDTH-1:0]  ptr;
  logic [INDEX_WIDTH-1:0]  grant;
  logic                    any_valid;
  logic                    load_en;
  logic                    load;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Output slot registers.
  logic [DATA_WIDTH-1:0]   data_p1;
  logic [INDEX_WIDTH-1:0]  index_p1;

  // Returns {found, channel}: the first valid channel met when searching
  // start, start+1, ... modulo NUM_INPUTS. The loop runs from the farthest
  // offset down to the nearest so the nearest hit is the one kept.
  function automatic logic [INDEX_WIDTH:0] rr_pick(
    input logic [NUM_INPUTS-1:0]  valid,
    input logic [INDEX_WIDTH-1:0] start
  );
    logic [INDEX_WIDTH:0]  res;
    logic [NUM_INPUTS-1:0] sh;
    int                    idx;
    res = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_INPUTS) begin
        idx = idx - NUM_INPUTS;
      end
      sh = valid >> idx;
      if (sh[0]) begin
        res = {1'b1, idx[INDEX_WIDTH-1:0]};
      end
    end
    return res;
  endfunction

  // Round-robin search from the pointer over the current requests.
  always_comb begin
    logic [INDEX_WIDTH:0] pick;
    pick      = rr_pick(ins_valid, ptr);
    any_valid = pick[INDEX_WIDTH];
    grant     = pick[INDEX_WIDTH-1:0];
  end

  // Payload multiplexer for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant == INDEX_WIDTH'(i)) begin
        sel_data = ins[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Slot next-state: fill when a request wins, drain when the consumer
  // takes the token and nothing replaces it.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    case (state)
      EMPTY: begin
        load_en = 1'b1;
        if (any_valid) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        load_en = outs_ready;
        if (outs_ready && !any_valid) begin
          state_nxt = EMPTY;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  assign load      = load_en & any_valid;
  assign ins_ready = load ? (NUM_INPUTS'(1) << grant) : '0;

  // Slot state register; reset discards any held token immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority pointer moves one past the winner on an accepted token only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      if (grant == INDEX_WIDTH'(NUM_INPUTS - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant + 1'b1;
      end
    end
  end

  // Capture payload and channel number into the output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1  <= '0;
      index_p1 <= '0;
    end else if (load) begin
      data_p1  <= sel_data;
      index_p1 <= grant;
    end
  end

  assign outs       = data_p1;
  assign index      = index_p1;
  assign outs_valid = (state == FULL);

`ifdef HANDSHAKE_RR_GRANT_CNT_EN
  logic [15:0] grant_cnt_q;

  // Saturating count of accepted input tokens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else if (load && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_q <= grant_cnt_q + 16'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_handshake_rr_control_merge.sv
// Testbench for handshake_rr_control_merge (NUM_INPUTS=4, DATA_WIDTH=8).
// Directed scenarios followed by constrained-random traffic, all checked
// against a transaction-level reference model of the merge.
module tb_handshake_rr_control_merge;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] ins;
  logic [N-1:0]    ins_valid;
  logic [N-1:0]    ins_ready;
  logic [DW-1:0]   outs;
  logic            outs_valid;
  logic            outs_ready;
  logic [IW-1:0]   index;
`ifdef HANDSHAKE_RR_GRANT_CNT_EN
  logic [15:0]     grant_cnt;
`endif

  handshake_rr_control_merge #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .outs      (outs),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready),
    .index     (index)
`ifdef HANDSHAKE_RR_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state.
  int          m_ptr;
  logic        m_valid;
  logic [7:0]  m_outs;
  int          m_idx;
`ifdef HANDSHAKE_RR_GRANT_CNT_EN
  logic [15:0] m_cnt;
`endif
  logic [N-1:0] acc;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic       cur_v [N];
  logic [7:0] cur_d [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_outs  = 8'h00;
    m_idx   = 0;
`ifdef HANDSHAKE_RR_GRANT_CNT_EN
    m_cnt   = 16'h0000;
`endif
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".outs_valid"}, 32'(outs_valid), 32'(m_valid));
    chk({tag, ".outs"}, 32'(outs), 32'(m_outs));
    chk({tag, ".index"}, 32'(index), 32'(m_idx));
`ifdef HANDSHAKE_RR_GRANT_CNT_EN
    chk({tag, ".grant_cnt"}, 32'(grant_cnt), 32'(m_cnt));
`endif
  endtask

  // One clock cycle with the currently driven inputs: check ready before
  // the edge, advance the model at the edge, check the slot after it.
  task automatic cycle(input string tag);
    int         g;
    logic       le;
    logic [N-1:0] exp_rdy;
    #1;
    g       = m_grant(ins_valid);
    le      = !m_valid || outs_ready;
    exp_rdy = (g >= 0 && le) ? N'(1 << g) : '0;
    chk({tag, ".ins_ready"}, 32'(ins_ready), 32'(exp_rdy));
    @(posedge clk);
    acc = exp_rdy;
    if (g >= 0 && le) begin
      m_outs  = ins[g*DW +: DW];
      m_idx   = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
`ifdef HANDSHAKE_RR_GRANT_CNT_EN
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end else if (m_valid && outs_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk_outputs(tag);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    m_reset();
    #2;
    chk_outputs("rst_pulse");
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    ins        = '0;
    ins_valid  = '0;
    outs_ready = 1'b0;
    acc        = '0;
    m_reset();

    // Reset then idle.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle("idle");

    // Single requester on channel 2.
    ins[2*DW +: DW] = 8'h39;
    ins_valid  = 4'b0100;
    outs_ready = 1'b1;
    cycle("single");
    chk("single.outs_const", 32'(outs), 32'h39);
    chk("single.index_const", 32'(index), 32'd2);
    ins_valid = 4'b0000;
    cycle("single_drain");

    // Fairness with all channels requesting.
    pulse_reset();
    ins        = {8'h44, 8'h33, 8'h22, 8'h11};
    ins_valid  = 4'b1111;
    outs_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle("fair");
      chk("fair.index_seq", 32'(index), 32'(k % N));
    end

    // Backpressure: hold A5 from channel 1, then drain with same-cycle refill.
    ins_valid = 4'b0010;
    ins[1*DW +: DW] = 8'hA5;
    ins[3*DW +: DW] = 8'h5A;
    cycle("bp_load");
    chk("bp_load.outs_const", 32'(outs), 32'hA5);
    outs_ready = 1'b0;
    ins_valid  = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      cycle("bp_hold");
      chk("bp_hold.outs_const", 32'(outs), 32'hA5);
      chk("bp_hold.index_const", 32'(index), 32'd1);
    end
    outs_ready = 1'b1;
    cycle("bp_refill");
    chk("bp_refill.outs_const", 32'(outs), 32'h5A);
    chk("bp_refill.valid_const", 32'(outs_valid), 32'd1);

    // Wrap and skip: put ptr at 3, then grant 1, then grant 0.
    ins_valid = 4'b0100;
    cycle("wrap_set");
    ins_valid = 4'b0010;
    cycle("wrap_g1");
    chk("wrap_g1.index_const", 32'(index), 32'd1);
    ins_valid = 4'b0011;
    cycle("wrap_g0");
    chk("wrap_g0.index_const", 32'(index), 32'd0);
    ins_valid = 4'b0000;
    cycle("wrap_drain");

    // Asynchronous reset while FULL and stalled.
    ins[0*DW +: DW] = 8'h77;
    ins_valid  = 4'b0001;
    cycle("mid_load");
    outs_ready = 1'b0;
    ins_valid  = 4'b0000;
    cycle("mid_hold");
    cycle("mid_hold");
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk_outputs("mid_rst");
    chk("mid_rst.valid_const", 32'(outs_valid), 32'd0);
    #2;
    rst = 1'b0;
    outs_ready = 1'b1;
    ins_valid  = 4'b1111;
    cycle("mid_after");
    chk("mid_after.index_const", 32'(index), 32'd0);

    // Randomized traffic with upstream stability honoured.
    ins_valid = '0;
    acc       = '0;
    for (int i = 0; i < N; i++) begin
      cur_v[i] = 1'b0;
      cur_d[i] = 8'h00;
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!cur_v[i] || acc[i]) begin
          cur_v[i] = ($urandom_range(0, 2) != 0);
          cur_d[i] = 8'($urandom);
        end
        ins_valid[i]    = cur_v[i];
        ins[i*DW +: DW] = cur_d[i];
      end
      outs_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
